// File: rtl/multiword_add_seq.sv
// Wide add/subtract sequencer: time-multiplexes one external N-bit adder slice
// over WORDS cycles (LSB slice first), chaining each slice's carry into the next.
module multiword_add_seq #(
   parameter int unsigned N     = 8,
   parameter int unsigned WORDS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N*WORDS-1:0]   op_a,
   input  logic [N*WORDS-1:0]   op_b,
   input  logic                 op_cin,
   input  logic                 op_sub,
   output logic [N-1:0]         add_a,
   output logic [N-1:0]         add_b,
   output logic                 add_cin,
   input  logic [N-1:0]         add_s,
   input  logic                 add_cout,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N*WORDS-1:0]   sum,
   output logic                 cout,
   output logic                 overflow
);

   localparam int unsigned W  = N * WORDS;
   localparam int unsigned KW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [KW-1:0] K_LAST     = KW'(WORDS - 1);
   localparam logic [W-1:0]  SLICE_MASK = W'({N{1'b1}});

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [KW-1:0]   k;
   logic            carry;
   logic [W-1:0]    a_reg;
   logic [W-1:0]    b_reg;
   logic [31:0]     shamt;
   logic            last_slice;

   assign shamt      = 32'(k) * 32'(N);
   assign last_slice = (k == K_LAST);

   // State register; out_valid is a flop that tracks entry into DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
      end else begin
         state     <= state_next;
         out_valid <= (state_next == DONE);
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid)  state_next = RUN;
         RUN:     if (last_slice) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs: handshake and the adder drive, quiet outside RUN
   always_comb begin
      in_ready = (state == IDLE);
      add_a    = '0;
      add_b    = '0;
      add_cin  = 1'b0;
      if (state == RUN) begin
         add_a   = N'(a_reg >> shamt);
         add_b   = N'(b_reg >> shamt);
         add_cin = carry;
      end
   end

   // Datapath: operand capture, per-slice result/carry writeback, final flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k        <= '0;
         carry    <= 1'b0;
         a_reg    <= '0;
         b_reg    <= '0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg <= op_a;
                  b_reg <= op_sub ? ~op_b : op_b;
                  carry <= op_sub | op_cin;
                  k     <= '0;
               end
            end
            RUN: begin
               sum   <= (sum & ~(SLICE_MASK << shamt)) | (W'(add_s) << shamt);
               carry <= add_cout;
               if (last_slice) begin
                  k        <= '0;
                  cout     <= add_cout;
                  // carry into the MSB is a^b^s at that bit
                  overflow <= add_cout ^ (add_a[N-1] ^ add_b[N-1] ^ add_s[N-1]);
               end else begin
                  k <= k + KW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/multiword_add_seq.md
Name: multiword_add_seq

Overview:
Sequencer that performs W = N*WORDS bit add/subtract by time-multiplexing one external N-bit lookahead adder slice over WORDS cycles, LSB slice first.
- Sits directly upstream and downstream of the adder. It drives the adder's a/b/cin inputs and registers its s/cout outputs, feeding each slice's cout back as the next slice's cin.
- Valid/ready handshakes on the operand side and on the result side.

Parameters:
N, 8, adder slice width in bits (must match the attached adder's N)
WORDS, 4, number of slices per operation (>=1); W = N*WORDS

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  operand request
in_ready  output  1  block can accept operands
op_a  input  W  operand A
op_b  input  W  operand B
op_cin  input  1  carry-in (ignored when op_sub=1)
op_sub  input  1  1: A-B, 0: A+B+op_cin
add_a  output  N  to adder a
add_b  output  N  to adder b
add_cin  output  1  to adder cin
add_s  input  N  from adder s
add_cout  input  1  from adder cout
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
sum  output  W  result
cout  output  1  raw carry out of MSB slice (for sub: 1 = no borrow)
overflow  output  1  two's-complement overflow

Behaviour:
- Interface: one clock clk; reset rst is asynchronous, active-high.
- Reset: state=IDLE, slice counter=0, carry reg=0, captured operands=0, sum=0, cout=0, overflow=0, out_valid=0. in_ready=(state==IDLE), so it reads 1 during and after reset.
- Reset asserted mid-operation aborts the operation. Partial results are discarded, no out_valid is produced, and the next operation starts clean.
- States:
  - IDLE: in_ready=1. On in_valid, capture A=op_a and B'=op_sub ? ~op_b : op_b. Carry reg = op_sub ? 1 : op_cin. k=0. Go to RUN.
  - RUN: in_ready=0. Combinationally add_a=A[k*N +: N], add_b=B'[k*N +: N], add_cin=carry reg.
    - Each rising edge: sum[k*N +: N]<=add_s, carry<=add_cout, k<=k+1.
    - On the edge where k==WORDS-1: cout<=add_cout; overflow<=add_cout ^ (add_a[N-1]^add_b[N-1]^add_s[N-1]); go to DONE, k<=0.
  - DONE: out_valid=1; sum/cout/overflow held stable. On out_valid&&out_ready, go to IDLE. out_valid is registered.
- Adder outputs outside RUN: add_a=0, add_b=0, add_cin=0.
- The attached adder is purely combinational. Its path from add_a/add_b/add_cin to add_s/add_cout is single-cycle.
- Latency: operands accepted on edge E → out_valid high after edge E+WORDS. Minimum issue interval is WORDS+2 cycles with out_ready held at 1.
- in_valid is ignored in RUN and DONE. op_* only need to be stable on the accept edge.
- sum keeps its last value after the handshake and is overwritten slice by slice during the next RUN. Consumers sample it only while out_valid=1.
- WORDS=1: RUN lasts one cycle. The counter is at least 1 bit wide.
- No sticky error state exists. Arithmetic is modulo 2^W.

Test Plan:
- N=8, WORDS=4, A=0xFFFFFFFF, B=0x00000001, sub=0, cin=0 → add_cin per RUN cycle 0,1,1,1; sum=0x00000000, cout=1, overflow=0; out_valid rises 4 cycles after accept.
- Sub: A=0x00000005, B=0x00000007, sub=1 → add_b first slice=0xF8, add_cin first=1; sum=0xFFFFFFFE, cout=0, overflow=0.
- Signed overflow: A=0x7FFFFFFF, B=0x00000001, sub=0 → sum=0x80000000, cout=0, overflow=1. Also A=0x80000000 - B=0x00000001 → sum=0x7FFFFFFF, overflow=1, cout=1.
- Back-pressure: out_ready=0 for 5 cycles after out_valid → sum/cout/overflow/out_valid stable, in_ready=0, a new in_valid pulse is ignored. out_ready=1 → IDLE next cycle, in_ready=1.
- Reset mid-RUN (after slice 1): in_ready=1, out_valid=0, sum=0 immediately (asynchronous). A following op 0x12345678+0x11111111 → 0x23456789, cout=0.
- Back-to-back with out_ready=1 and in_valid=1: accepts spaced exactly 6 cycles apart; cin=1 on 0x000000FF+0x00000000 → 0x00000100.
